// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin sharing of one WIDTH-bit up-counter between NUM_REQ requesters.
// Define COUNTER_SCHEDULER_ABORT_EN to abort a run when the owner drops req during RUN.
module counter_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] req_len,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     busy,
   output logic [WIDTH-1:0]         counter_output,
   output logic [NUM_REQ-1:0]       done
);
   localparam int IW = $clog2(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_n;
   logic [IW-1:0] last, last_n, pick;
   logic [WIDTH-1:0] target, target_n, count_n;
   logic [NUM_REQ-1:0] grant_n, done_n;
   logic busy_n, hit, abort;
`ifdef COUNTER_SCHEDULER_ABORT_EN
   assign abort = ~req[last];
`else
   assign abort = 1'b0;
`endif
   // Scan downward so the requester closest after last wins.
   always_comb begin
      pick = last;
      hit  = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (req[(int'(last) + k) % NUM_REQ]) begin
            pick = IW'((int'(last) + k) % NUM_REQ);
            hit  = 1'b1;
         end
      end
   end
   always_comb begin
      state_n  = state;
      last_n   = last;
      target_n = target;
      grant_n  = grant;
      busy_n   = busy;
      count_n  = counter_output;
      done_n   = '0;
      case (state)
         IDLE: if (hit) begin
            state_n  = RUN;
            last_n   = pick;
            target_n = req_len[int'(pick)*WIDTH +: WIDTH];
            grant_n  = ONE << pick;
            busy_n   = 1'b1;
            count_n  = '0;
         end
         RUN: if (abort) begin
            state_n = IDLE;
            grant_n = '0;
            busy_n  = 1'b0;
            count_n = '0;
         end else if (counter_output == target) begin
            state_n = DONE;
            grant_n = '0;
            busy_n  = 1'b0;
            done_n  = ONE << last;
         end else begin
            count_n = counter_output + 1'b1;
         end
         DONE: begin
            state_n = IDLE;
            count_n = '0;
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
            busy_n  = 1'b0;
            count_n = '0;
         end
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         last           <= IW'(NUM_REQ - 1);
         target         <= '0;
         grant          <= '0;
         busy           <= 1'b0;
         counter_output <= '0;
         done           <= '0;
      end else begin
         state          <= state_n;
         last           <= last_n;
         target         <= target_n;
         grant          <= grant_n;
         busy           <= busy_n;
         counter_output <= count_n;
         done           <= done_n;
      end
   end
endmodule

// File: tb/tb_counter_scheduler.sv
// tb_counter_scheduler: directed self-checking bench for counter_scheduler (NUM_REQ=4, WIDTH=8).
module tb_counter_scheduler;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [3:0] req = '0;
   logic [31:0] req_len = '0;
   logic [3:0] grant, done;
   logic busy;
   logic [7:0] counter_output;
   int n_chk = 0;
   int n_pass = 0;

   counter_scheduler #(.NUM_REQ(4), .WIDTH(8)) dut (
      .clk(clk), .reset(reset), .req(req), .req_len(req_len),
      .grant(grant), .busy(busy), .counter_output(counter_output), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      req = '0;
      req_len = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      n_chk++;
      if ({grant, busy, counter_output, done} !== 17'h0)
         $display("FAIL reset_state: got grant=%b busy=%b cnt=%0d done=%b, want all zero", grant, busy, counter_output, done);
      else n_pass++;
      req = 4'b0010;
      req_len[8 +: 8] = 8'd10;
      tick(6);
      n_chk++;
      if (grant !== 4'b0010 || counter_output !== 8'd5)
         $display("FAIL midrun_setup: got grant=%b cnt=%0d, want 0010/5", grant, counter_output);
      else n_pass++;
      reset = 1'b1;
      #1;
      n_chk++;
      if ({grant, busy, counter_output, done} !== 17'h0)
         $display("FAIL async_reset: got grant=%b busy=%b cnt=%0d done=%b, want all zero", grant, busy, counter_output, done);
      else n_pass++;
      tick();
      reset = 1'b0;
      req = 4'b1111;
      tick();
      n_chk++;
      if (grant !== 4'b0001 || busy !== 1'b1)
         $display("FAIL reset_priority: got grant=%b busy=%b, want 0001/1", grant, busy);
      else n_pass++;
   endtask

   task automatic test_single_run;
      do_reset();
      req = 4'b0100;
      req_len[16 +: 8] = 8'd3;
      tick();
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if (grant !== 4'b0100 || busy !== 1'b1 || counter_output !== 8'(i) || done !== 4'b0)
            $display("FAIL single_run_%0d: got grant=%b busy=%b cnt=%0d done=%b, want 0100/1/%0d/0000", i, grant, busy, counter_output, done, i);
         else n_pass++;
         tick();
      end
      n_chk++;
      if (done !== 4'b0100 || grant !== 4'b0 || busy !== 1'b0 || counter_output !== 8'd3)
         $display("FAIL single_done: got done=%b grant=%b busy=%b cnt=%0d, want 0100/0000/0/3", done, grant, busy, counter_output);
      else n_pass++;
      req = '0;
      tick();
      n_chk++;
      if (done !== 4'b0 || grant !== 4'b0 || counter_output !== 8'd0)
         $display("FAIL single_idle: got done=%b grant=%b cnt=%0d, want 0000/0000/0", done, grant, counter_output);
      else n_pass++;
      tick();
      n_chk++;
      if (grant !== 4'b0 || busy !== 1'b0)
         $display("FAIL idle_stays: got grant=%b busy=%b, want 0000/0", grant, busy);
      else n_pass++;
   endtask

   task automatic test_round_robin;
      logic [3:0] exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_chk++;
         if (grant !== exp[i] || counter_output !== 8'd0)
            $display("FAIL rr_grant_%0d: got grant=%b cnt=%0d, want %b/0", i, grant, counter_output, exp[i]);
         else n_pass++;
         tick();
         n_chk++;
         if (grant !== 4'b0 || done !== exp[i])
            $display("FAIL rr_done_%0d: got grant=%b done=%b, want 0000/%b", i, grant, done, exp[i]);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_back_to_back;
      int bad = 0;
      do_reset();
      req = 4'b0100;
      req_len[16 +: 8] = 8'd200;
      tick();
      req[0] = 1'b1;
      for (int i = 0; i <= 200; i++) begin
         if (grant !== 4'b0100 || counter_output !== 8'(i)) bad++;
         tick();
      end
      n_chk++;
      if (bad != 0) $display("FAIL long_hold: got %0d bad RUN cycles, want 0", bad);
      else n_pass++;
      n_chk++;
      if (done !== 4'b0100 || counter_output !== 8'd200)
         $display("FAIL long_done: got done=%b cnt=%0d, want 0100/200", done, counter_output);
      else n_pass++;
      req[2] = 1'b0;
      tick();
      n_chk++;
      if (grant !== 4'b0) $display("FAIL long_gap: got grant=%b, want 0000", grant);
      else n_pass++;
      tick();
      n_chk++;
      if (grant !== 4'b0001) $display("FAIL long_next: got grant=%b, want 0001", grant);
      else n_pass++;
   endtask

   task automatic test_max_len;
      int bad = 0;
      do_reset();
      req = 4'b0001;
      req_len[7:0] = 8'd255;
      tick();
      for (int i = 0; i <= 255; i++) begin
         if (grant !== 4'b0001 || counter_output !== 8'(i) || done !== 4'b0) bad++;
         tick();
      end
      n_chk++;
      if (bad != 0) $display("FAIL max_run: got %0d bad RUN cycles, want 0", bad);
      else n_pass++;
      n_chk++;
      if (done !== 4'b0001 || counter_output !== 8'd255)
         $display("FAIL max_done: got done=%b cnt=%0d, want 0001/255", done, counter_output);
      else n_pass++;
      req = '0;
      tick();
      n_chk++;
      if (counter_output !== 8'd0) $display("FAIL max_idle: got cnt=%0d, want 0", counter_output);
      else n_pass++;
   endtask

   task automatic test_abort;
      do_reset();
      req = 4'b1010;
      req_len[8 +: 8] = 8'd10;
      tick();
      tick(4);
      n_chk++;
      if (grant !== 4'b0010 || counter_output !== 8'd4)
         $display("FAIL abort_setup: got grant=%b cnt=%0d, want 0010/4", grant, counter_output);
      else n_pass++;
      req = 4'b1000;
      tick();
`ifdef COUNTER_SCHEDULER_ABORT_EN
      n_chk++;
      if (grant !== 4'b0 || busy !== 1'b0 || counter_output !== 8'd0 || done !== 4'b0)
         $display("FAIL abort_idle: got grant=%b busy=%b cnt=%0d done=%b, want 0000/0/0/0000", grant, busy, counter_output, done);
      else n_pass++;
`else
      n_chk++;
      if (grant !== 4'b0010 || counter_output !== 8'd5)
         $display("FAIL noabort_run: got grant=%b cnt=%0d, want 0010/5", grant, counter_output);
      else n_pass++;
      tick(6);
      n_chk++;
      if (done !== 4'b0010 || counter_output !== 8'd10)
         $display("FAIL noabort_done: got done=%b cnt=%0d, want 0010/10", done, counter_output);
      else n_pass++;
      tick();
`endif
      tick();
      n_chk++;
      if (grant !== 4'b1000) $display("FAIL abort_next: got grant=%b, want 1000", grant);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_run();
      test_round_robin();
      test_back_to_back();
      test_max_len();
      test_abort();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/counter_scheduler.md
Name: counter_scheduler

Overview:
- Shares one WIDTH-bit up-counter between NUM_REQ requesters.
- Each requester asks for a run of a programmed length. The block arbitrates round-robin, sequences the counter from 0 to that length, pulses done, then releases the counter.
- Sits between the requesting control blocks and the counter datapath. counter_output is the shared count value.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, counter and length width in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level.
- req_len  input  NUM_REQ*WIDTH  flattened run lengths; requester i uses bits [i*WIDTH +: WIDTH].
- grant  output  NUM_REQ  one-hot owner of the counter; all zero when unowned.
- busy  output  1  high while the counter is owned (state RUN).
- counter_output  output  WIDTH  shared counter value.
- done  output  NUM_REQ  one-cycle completion pulse to the owner.

Behaviour:
- Reset (asynchronous, effective immediately):
  - state=IDLE; grant=0, busy=0, counter_output=0, done=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority after reset.
  - Reset mid-run aborts the run silently: no done pulse.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - If req!=0 at a rising edge, pick the winner: first set bit searching last+1, last+2, ... (mod NUM_REQ).
  - Next cycle: state=RUN, grant=onehot(winner), busy=1, counter_output=0.
  - Latch target=req_len[winner] and set last=winner.
  - If req==0, stay in IDLE with outputs unchanged (counter_output=0).
- RUN:
  - If counter_output==target: next state=DONE, done[winner]=1, grant=0, busy=0. counter_output holds target for the DONE cycle.
  - Otherwise counter_output increments by 1.
  - RUN therefore lasts target+1 cycles; target=0 gives one RUN cycle.
  - req_len changes after the latch are ignored.
  - Deasserting req[winner] during RUN is ignored (see optional feature).
- DONE:
  - Lasts one cycle. Next cycle: state=IDLE, done=0, counter_output=0.
- Request-to-grant latency: 1 cycle from the sampling edge in IDLE. Minimum service period per request: target+3 cycles (IDLE, RUN×(target+1), DONE).
- Requester protocol: a requester holds req until its done pulse. It must drop req in the cycle after done unless it wants another run; the level is sampled again in IDLE.
- If the winner is the only requester still asserted in IDLE, it is granted again; the pointer just rotates back to it.
- Simultaneous requests: strict rotation. With all NUM_REQ requesters asserted, each is served once per NUM_REQ grants.
- No wrap-around: target is at most 2^WIDTH-1, so counter_output never overflows.
- Invariants:
  - grant is zero or one-hot.
  - busy equals |grant.
  - done is zero or one-hot, and never overlaps grant.

Optional Feature:
- Macro: COUNTER_SCHEDULER_ABORT_EN.
- Defined:
  - In RUN, if req[winner]==0 at an edge, abort: next cycle state=IDLE, grant=0, busy=0, counter_output=0, no done pulse.
  - last still equals the aborted winner, so rotation continues past it.
  - Abort takes priority over completion when both occur on the same edge.
- Undefined:
  - req is ignored during RUN, and every granted run completes with done.

Test Plan:
1. Reset high mid-RUN (grant=0010, counter_output=5) → immediately grant=0, busy=0, counter_output=0, done=0. After release, req=1111 → grant=0001 first.
2. req=0100 with len2=3 → grant=0100 one cycle after sampling. counter_output 0,1,2,3 over four RUN cycles, then done=0100 for one cycle with counter_output=3. IDLE follows with counter_output=0.
3. req=1111, all lengths=0 → grants in order 0001, 0010, 0100, 1000, 0001. Each grant lasts 1 cycle and each is followed by a done pulse to the same requester.
4. Requester 2 running len=200 while req0 rises → grant stays 0100 for all 201 RUN cycles. grant=0001 follows two cycles after done=0100.
5. len=255 (max) → counter_output reaches 255 without wrapping, then done fires.
6. COUNTER_SCHEDULER_ABORT_EN defined, requester 1 drops req at counter_output=4 → grant=0 and counter_output=0 next cycle, no done. Pending req3 is granted next. With the macro undefined, the same stimulus completes with done=0010.
